// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: hex font table,
// segment width and the output polarity helper.
package sseg_pkg;

  localparam int SEG_W = 7;
  localparam int NIB_W = 4;

  // Active-high {g,f,e,d,c,b,a} patterns, entry n at bits [n*SEG_W +: SEG_W]
  localparam logic [16*SEG_W-1:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [SEG_W-1:0] apply_seg_polarity(
    input logic [SEG_W-1:0] seg_hi,
    input logic             active_low
  );
    return active_low ? ~seg_hi : seg_hi;
  endfunction

endpackage

// File: rtl/sseg_font_rom.sv
// Combinational hex nibble to active-high seven-segment pattern lookup.
module sseg_font_rom
  import sseg_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] segments
);

  assign segments = HEX_FONT[nibble*SEG_W +: SEG_W];

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with double-buffered display data.
// Optional SSEG_LEADING_ZERO_BLANK_EN: auto-blank digits above the highest non-zero nibble.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_HZ         = 100_000_000,
  parameter int REFRESH_HZ     = 1000,
  parameter int GHOST_CYCLES   = 16,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NIB_W*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic [NUM_DIGITS-1:0]       blank_in,
  input  logic                        load,
  output logic [SEG_W-1:0]            seg,
  output logic                        dp,
  output logic [NUM_DIGITS-1:0]       an,
  output logic                        frame_tick
);

  localparam int TICK_DIV = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W    = NIB_W * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GHOST_START = CNT_W'(GHOST_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [VAL_W-1:0]      active_value_reg, pending_value_reg;
  logic [NUM_DIGITS-1:0] active_dp_reg, pending_dp_reg;
  logic [NUM_DIGITS-1:0] active_blank_reg, pending_blank_reg;
  logic                  pending_valid_reg;
  logic [SEG_W-1:0]      seg_reg;
  logic                  dp_reg;
  logic [NUM_DIGITS-1:0] an_reg;

  logic                  tick, wrap;
  logic [VAL_W-1:0]      commit_value;
  logic [NUM_DIGITS-1:0] commit_dp, commit_blank;
  logic [NIB_W-1:0]      value_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] digit_sel;
  logic [NIB_W-1:0]      cur_nib;
  logic [SEG_W-1:0]      font_seg;
  logic                  digit_lz;
  logic                  an_on;
  logic [NUM_DIGITS-1:0] an_next;
  logic [SEG_W-1:0]      seg_next;
  logic                  dp_next;

  assign tick       = (cnt_reg == CNT_LAST);
  assign wrap       = tick && (idx_reg == IDX_LAST);
  assign frame_tick = wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else begin
      cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
      if (tick) begin
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end
    end
  end

  // A load coinciding with the wrap bypasses pending and goes straight to active
  assign commit_value = load ? value    : pending_value_reg;
  assign commit_dp    = load ? dp_in    : pending_dp_reg;
  assign commit_blank = load ? blank_in : pending_blank_reg;

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] active_lz_reg;
  logic [NUM_DIGITS-1:0] lz_next;
  logic                  lz_seen;

  always_comb begin
    lz_next = '0;
    lz_seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_seen    = lz_seen | (|commit_value[i*NIB_W +: NIB_W]);
      lz_next[i] = !lz_seen;
    end
  end

  assign digit_lz = active_lz_reg[idx_reg];
`else
  assign digit_lz = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_value_reg  <= '0;
      active_dp_reg     <= '0;
      active_blank_reg  <= '0;
      pending_value_reg <= '0;
      pending_dp_reg    <= '0;
      pending_blank_reg <= '0;
      pending_valid_reg <= 1'b0;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      active_lz_reg     <= '0;
`endif
    end else if (wrap) begin
      if (load || pending_valid_reg) begin
        active_value_reg <= commit_value;
        active_dp_reg    <= commit_dp;
        active_blank_reg <= commit_blank;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        active_lz_reg    <= lz_next;
`endif
      end
      pending_valid_reg <= 1'b0;
    end else if (load) begin
      pending_value_reg <= value;
      pending_dp_reg    <= dp_in;
      pending_blank_reg <= blank_in;
      pending_valid_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign value_nib[gi] = active_value_reg[gi*NIB_W +: NIB_W];
    assign digit_sel[gi] = (idx_reg == IDX_W'(gi));
  end

  assign cur_nib = value_nib[idx_reg];

  sseg_font_rom u_font_rom (
    .nibble   (cur_nib),
    .segments (font_seg)
  );

  // Auto-blanked digits keep their anode on only to show a requested dp
  always_comb begin
    an_on    = (cnt_reg >= GHOST_START) && !active_blank_reg[idx_reg]
               && (!digit_lz || active_dp_reg[idx_reg]);
    an_next  = an_on ? digit_sel : '0;
    seg_next = (an_on && !digit_lz) ? font_seg : '0;
    dp_next  = an_on && active_dp_reg[idx_reg];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_reg  <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      seg_reg <= apply_seg_polarity('0, SEG_ACTIVE_LOW);
      dp_reg  <= SEG_ACTIVE_LOW;
    end else begin
      an_reg  <= an_next ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
      seg_reg <= apply_seg_polarity(seg_next, SEG_ACTIVE_LOW);
      dp_reg  <= dp_next ^ SEG_ACTIVE_LOW;
    end
  end

  assign seg = seg_reg;
  assign dp  = dp_reg;
  assign an  = an_reg;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver: 4 digits, 8 cycles per digit, 2 ghost cycles.
module tb_sseg_scan_driver;

  localparam int ND    = 4;
  localparam int CPD   = 8;
  localparam int GHOST = 2;
  localparam int FRAME = ND * CPD;

  logic        clk;
  logic        reset_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  sseg_scan_driver #(
    .NUM_DIGITS     (ND),
    .CLK_HZ         (800),
    .REFRESH_HZ     (25),
    .GHOST_CYCLES   (GHOST),
    .AN_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .value      (value),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .load       (load),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] font_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int          m_cyc;
  logic [15:0] m_val, m_pval;
  logic [3:0]  m_dp, m_pdp, m_bl, m_pbl, m_lz;
  logic        m_pv;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_ft;

  assign exp_ft = reset_n && ((m_cyc % FRAME) == FRAME - 1);

  function automatic logic [3:0] lz_of(input logic [15:0] v);
    logic [3:0] r;
    r = 4'b0000;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    for (int d = 1; d < ND; d++) r[d] = ((v >> (4 * d)) == 16'h0);
`endif
    return r;
  endfunction

  function automatic logic lit_of(input int cyc, input logic [3:0] bl, input logic [3:0] dpm,
                                  input logic [3:0] lz);
    int d;
    int c;
    d = (cyc / CPD) % ND;
    c = cyc % CPD;
    return (c >= GHOST) && !bl[d] && (!lz[d] || dpm[d]);
  endfunction

  function automatic logic [3:0] f_an(input int cyc, input logic [3:0] bl, input logic [3:0] dpm,
                                      input logic [3:0] lz);
    int d;
    d = (cyc / CPD) % ND;
    return lit_of(cyc, bl, dpm, lz) ? ~(4'b0001 << d) : 4'hF;
  endfunction

  function automatic logic [6:0] f_seg(input int cyc, input logic [15:0] v, input logic [3:0] bl,
                                       input logic [3:0] dpm, input logic [3:0] lz);
    int d;
    logic [15:0] sh;
    d  = (cyc / CPD) % ND;
    sh = v >> (4 * d);
    return (lit_of(cyc, bl, dpm, lz) && !lz[d]) ? ~font_hi[sh[3:0]] : 7'h7F;
  endfunction

  function automatic logic f_dp(input int cyc, input logic [3:0] bl, input logic [3:0] dpm,
                                input logic [3:0] lz);
    int d;
    d = (cyc / CPD) % ND;
    return !(lit_of(cyc, bl, dpm, lz) && dpm[d]);
  endfunction

  // m_cyc = rising edges since reset release; outputs after an edge reflect the pre-edge position
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cyc <= 0;
      m_val <= '0; m_dp <= '0; m_bl <= '0; m_lz <= '0;
      m_pval <= '0; m_pdp <= '0; m_pbl <= '0; m_pv <= 1'b0;
      exp_an <= 4'hF; exp_seg <= 7'h7F; exp_dp <= 1'b1;
    end else begin
      exp_an  <= f_an(m_cyc, m_bl, m_dp, m_lz);
      exp_seg <= f_seg(m_cyc, m_val, m_bl, m_dp, m_lz);
      exp_dp  <= f_dp(m_cyc, m_bl, m_dp, m_lz);
      if ((m_cyc % FRAME) == FRAME - 1) begin
        if (load) begin
          m_val <= value; m_dp <= dp_in; m_bl <= blank_in; m_lz <= lz_of(value);
        end else if (m_pv) begin
          m_val <= m_pval; m_dp <= m_pdp; m_bl <= m_pbl; m_lz <= lz_of(m_pval);
        end
        m_pv <= 1'b0;
      end else if (load) begin
        m_pval <= value; m_pdp <= dp_in; m_pbl <= blank_in; m_pv <= 1'b1;
      end
      m_cyc <= m_cyc + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp_in = d; blank_in = b; load = 1'b1;
    $display("load value=%h dp=%b blank=%b t=%0t", v, d, b, $time);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 3 * FRAME);
    if (frame_tick !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_frame: frame_tick=%b after %0d cycles, required 1", frame_tick, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    reset_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_in = '0;
    repeat (3) @(negedge clk);
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an: got %b required 1111", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h required 7f", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b required 1", dp); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_ft: got %b required 0", frame_tick); end
    reset_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || frame_tick !== exp_ft) begin
        errors++;
        $display("FAIL reset_model t=%0t an=%b/%b seg=%h/%h dp=%b/%b ft=%b/%b",
                 $time, an, exp_an, seg, exp_seg, dp, exp_dp, frame_tick, exp_ft);
      end
    end while (frame_tick !== 1'b1 && n < 100);
    // frame_tick is sampled by the 32nd rising edge after release
    checks++;
    if (n + 1 !== 32) begin errors++; $display("FAIL first_frame_tick: edge %0d required 32", n + 1); end
  endtask

  task automatic test_digits();
    logic [6:0] want [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
    logic [6:0] seen [4];
    int         lit_cnt [4];
    int         d;
    for (int k = 0; k < 4; k++) begin seen[k] = 7'h7F; lit_cnt[k] = 0; end
    @(negedge clk);
    do_load(16'h12AF, 4'b0000, 4'b0000);
    wait_frame();
    @(negedge clk);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || frame_tick !== exp_ft) begin
        errors++;
        $display("FAIL digits_model t=%0t an=%b/%b seg=%h/%h dp=%b/%b ft=%b/%b",
                 $time, an, exp_an, seg, exp_seg, dp, exp_dp, frame_tick, exp_ft);
      end
      if (an !== 4'hF) begin
        checks++;
        if ($countones(~an) != 1) begin errors++; $display("FAIL digits_onehot: an=%b required one low", an); end
        d = 0;
        for (int k = 0; k < 4; k++) if (an[k] === 1'b0) d = k;
        seen[d] = seg;
        lit_cnt[d]++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seen[k] !== want[k]) begin errors++; $display("FAIL digit%0d_seg: got %h required %h", k, seen[k], want[k]); end
      checks++;
      if (lit_cnt[k] != CPD - GHOST) begin errors++; $display("FAIL digit%0d_lit: got %0d required %0d", k, lit_cnt[k], CPD - GHOST); end
    end
  endtask

  task automatic test_double_load();
    wait_frame();
    @(negedge clk);
    do_load(16'h1111, 4'b0000, 4'b0000);
    repeat (4) @(negedge clk);
    do_load(16'h2222, 4'b0000, 4'b0000);
    wait_frame();
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || frame_tick !== exp_ft) begin
        errors++;
        $display("FAIL double_model t=%0t an=%b/%b seg=%h/%h dp=%b/%b ft=%b/%b",
                 $time, an, exp_an, seg, exp_seg, dp, exp_dp, frame_tick, exp_ft);
      end
      if (i > 0 && an !== 4'hF) begin
        checks++;
        if (seg !== 7'h24) begin errors++; $display("FAIL double_load: seg=%h required 24 (digit 2)", seg); end
      end
    end
  endtask

  task automatic test_load_on_wrap();
    wait_frame();
    do_load(16'h0005, 4'b0000, 4'b0000);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || frame_tick !== exp_ft) begin
        errors++;
        $display("FAIL wrap_model t=%0t an=%b/%b seg=%h/%h dp=%b/%b ft=%b/%b",
                 $time, an, exp_an, seg, exp_seg, dp, exp_dp, frame_tick, exp_ft);
      end
      if (an === 4'b1110) begin
        checks++;
        if (seg !== 7'h12) begin errors++; $display("FAIL wrap_digit0: seg=%h required 12", seg); end
      end else if (an !== 4'hF) begin
        checks++;
        if (seg !== 7'h40) begin errors++; $display("FAIL wrap_upper: seg=%h required 40", seg); end
      end
    end
  endtask

  task automatic test_blank_dp();
    @(negedge clk);
    do_load(16'($urandom), 4'b0001, 4'b0100);
    wait_frame();
    @(negedge clk);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || frame_tick !== exp_ft) begin
        errors++;
        $display("FAIL blank_model t=%0t an=%b/%b seg=%h/%h dp=%b/%b ft=%b/%b",
                 $time, an, exp_an, seg, exp_seg, dp, exp_dp, frame_tick, exp_ft);
      end
      checks++;
      if (an[2] !== 1'b1) begin errors++; $display("FAIL blank_an2: an=%b required an[2]=1", an); end
      checks++;
      if ((dp === 1'b0) !== (an === 4'b1110)) begin
        errors++; $display("FAIL dp_digit0: dp=%b an=%b required dp low only in digit0 slot", dp, an);
      end
    end
  endtask

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  task automatic test_lzb();
    @(negedge clk);
    do_load(16'h0030, 4'b0000, 4'b0000);
    wait_frame();
    for (int i = 0; i < FRAME + 1; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (an[3] !== 1'b1 || an[2] !== 1'b1) begin errors++; $display("FAIL lzb_0030: an=%b required digits 3,2 dark", an); end
      end
    end
    do_load(16'h0000, 4'b0000, 4'b0000);
    wait_frame();
    for (int i = 0; i < FRAME + 1; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        errors++; $display("FAIL lzb_model an=%b/%b seg=%h/%h dp=%b/%b", an, exp_an, seg, exp_seg, dp, exp_dp);
      end
      if (i > 0) begin
        checks++;
        if (an !== 4'hF && !(an === 4'b1110 && seg === 7'h40)) begin
          errors++; $display("FAIL lzb_zero: an=%b seg=%h required only digit0 showing 0", an, seg);
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    int gap;
    for (int t = 0; t < 10; t++) begin
      gap = $urandom_range(0, 40);
      for (int i = 0; i < gap; i++) begin
        @(negedge clk);
        checks++;
        if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || frame_tick !== exp_ft) begin
          errors++;
          $display("FAIL random_model t=%0t an=%b/%b seg=%h/%h dp=%b/%b ft=%b/%b",
                   $time, an, exp_an, seg, exp_seg, dp, exp_dp, frame_tick, exp_ft);
        end
      end
      do_load(16'($urandom), 4'($urandom), 4'($urandom));
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || frame_tick !== exp_ft) begin
        errors++;
        $display("FAIL random_model t=%0t an=%b/%b seg=%h/%h dp=%b/%b ft=%b/%b",
                 $time, an, exp_an, seg, exp_seg, dp, exp_dp, frame_tick, exp_ft);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_load(16'h4321, 4'b0000, 4'b0000);
    n = 0;
    while (an !== 4'b1011 && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (an !== 4'b1011) begin errors++; $display("FAIL reset_mid_wait: an=%b required 1011", an); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      errors++; $display("FAIL reset_mid_async: an=%b seg=%h dp=%b required 1111/7f/1", an, seg, dp);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 2 * CPD; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || frame_tick !== exp_ft) begin
        errors++;
        $display("FAIL reset_mid_model t=%0t an=%b/%b seg=%h/%h dp=%b/%b ft=%b/%b",
                 $time, an, exp_an, seg, exp_seg, dp, exp_dp, frame_tick, exp_ft);
      end
      if (i == GHOST + 1) begin
        checks++;
        if (an !== 4'b1110) begin errors++; $display("FAIL reset_mid_resume: an=%b required 1110", an); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_double_load();
    test_load_on_wrap();
    test_blank_dp();
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    test_lzb();
`endif
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
